// File: rtl/booth_mac_pkg.sv
// Shared types, widths and the saturating adder used by the Booth multiply-accumulate stage.
package booth_mac_pkg;

   typedef enum logic [1:0] {ACC, DRAIN, OUT} mac_state_t;

   localparam int unsigned OP_W      = 8;
   localparam int unsigned PROD_W    = 16;
   localparam int unsigned SAT_MAX_W = 64;

   // Operands arrive sign-extended to SAT_MAX_W; the result clamps to the signed range of w bits.
   function automatic logic [SAT_MAX_W-1:0] sat_add(input  logic signed [SAT_MAX_W-1:0] a,
                                                    input  logic signed [SAT_MAX_W-1:0] b,
                                                    input  int unsigned                 w,
                                                    output logic                        ovf);
      logic signed [SAT_MAX_W:0] sum;
      logic signed [SAT_MAX_W:0] hi;
      logic signed [SAT_MAX_W:0] lo;
      logic        [SAT_MAX_W:0] one;
      one = {{SAT_MAX_W{1'b0}}, 1'b1};
      sum = {a[SAT_MAX_W-1], a} + {b[SAT_MAX_W-1], b};
      hi  = (one << (w - 1)) - one;
      lo  = ~hi;
      ovf = 1'b0;
      if (sum > hi) begin
         ovf = 1'b1;
         return hi[SAT_MAX_W-1:0];
      end
      if (sum < lo) begin
         ovf = 1'b1;
         return lo[SAT_MAX_W-1:0];
      end
      return sum[SAT_MAX_W-1:0];
   endfunction

endpackage

// File: rtl/boothmul.sv
// Combinational 8x8 signed radix-4 Booth multiplier producing a 16-bit signed product.
module boothmul
   import booth_mac_pkg::*;
(
   input  logic [OP_W-1:0]   a,
   input  logic [OP_W-1:0]   b,
   output logic [PROD_W-1:0] prod
);

   logic [PROD_W-1:0] a_ext;
   logic [OP_W:0]     b_ext;
   logic [PROD_W-1:0] pp;

   assign a_ext = PROD_W'($signed(a));
   assign b_ext = {b, 1'b0};

   // Each overlapping triplet of the multiplier selects 0, +-a or +-2a, weighted by 4^i.
   always_comb begin
      prod = '0;
      pp   = '0;
      for (int i = 0; i < OP_W / 2; i++) begin
         case (b_ext[2*i +: 3])
            3'b001, 3'b010: pp = a_ext;
            3'b011:         pp = a_ext << 1;
            3'b100:         pp = -(a_ext << 1);
            3'b101, 3'b110: pp = -a_ext;
            default:        pp = '0;
         endcase
         prod = prod + (pp << (2 * i));
      end
   end

endmodule

// File: rtl/booth_mac_unit.sv
// Packet multiply-accumulate stage: registers operand pairs in front of boothmul and sums
// the products of each packet into a saturating signed accumulator.
module booth_mac_unit
   import booth_mac_pkg::*;
#(
   parameter int unsigned ACC_W = 24,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OP_W-1:0]  in_a,
   input  logic [OP_W-1:0]  in_b,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_acc,
   output logic [CNT_W-1:0] out_count,
   output logic             out_sat
);

   mac_state_t state_q, state_d;

   logic [OP_W-1:0]   op_a_q, op_b_q;
   logic              op_last_q, op_valid_q;
   logic [PROD_W-1:0] prod;

   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    sat_q, sat_d;

   logic [ACC_W-1:0] out_acc_q, out_acc_d;
   logic [CNT_W-1:0] out_count_q, out_count_d;
   logic             out_sat_q, out_sat_d;

   logic                    accept;
   logic signed [ACC_W-1:0] sum_clamp;
   logic                    add_ovf;
   logic [CNT_W-1:0]        cnt_inc;

   boothmul u_boothmul (
      .a    (op_a_q),
      .b    (op_b_q),
      .prod (prod)
   );

   assign in_ready  = (state_q == ACC) && rst_n;
   assign accept    = in_valid && in_ready;
   assign out_valid = (state_q == OUT);
   assign out_acc   = out_acc_q;
   assign out_count = out_count_q;
   assign out_sat   = out_sat_q;

   assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

   always_comb begin
      add_ovf   = 1'b0;
      sum_clamp = ACC_W'(sat_add(SAT_MAX_W'(acc_q), SAT_MAX_W'($signed(prod)), ACC_W, add_ovf));
   end

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      sat_d       = sat_q;
      out_acc_d   = out_acc_q;
      out_count_d = out_count_q;
      out_sat_d   = out_sat_q;

      if (op_valid_q) begin
         acc_d = sum_clamp;
         cnt_d = cnt_inc;
         sat_d = sat_q | add_ovf;
      end

      // Final term: publish the packet and start the next one from zero.
      if (op_valid_q && op_last_q) begin
         out_acc_d   = sum_clamp;
         out_count_d = cnt_inc;
         out_sat_d   = sat_q | add_ovf;
         acc_d       = '0;
         cnt_d       = '0;
         sat_d       = 1'b0;
      end

      case (state_q)
         ACC:     if (accept && in_last) state_d = DRAIN;
         DRAIN:   state_d = OUT;
         OUT:     if (out_ready) state_d = ACC;
         default: state_d = ACC;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ACC;
         op_a_q      <= '0;
         op_b_q      <= '0;
         op_last_q   <= 1'b0;
         op_valid_q  <= 1'b0;
         acc_q       <= '0;
         cnt_q       <= '0;
         sat_q       <= 1'b0;
         out_acc_q   <= '0;
         out_count_q <= '0;
         out_sat_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_valid_q  <= accept;
         if (accept) begin
            op_a_q    <= in_a;
            op_b_q    <= in_b;
            op_last_q <= in_last;
         end
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         sat_q       <= sat_d;
         out_acc_q   <= out_acc_d;
         out_count_q <= out_count_d;
         out_sat_q   <= out_sat_d;
      end
   end

endmodule

// File: tb/tb_booth_mac_unit.sv
// Randomised and directed bench for booth_mac_unit with a plain-arithmetic packet model.
module tb_booth_mac_unit;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // sel=0: 24-bit accumulator instance, sel=1: 16-bit instance
   logic       iv0, ir0, il0, ov0, or0, os0;
   logic [7:0] ia0, ib0, oc0;
   logic [23:0] oa0;
   logic       iv1, ir1, il1, ov1, or1, os1;
   logic [7:0] ia1, ib1, oc1;
   logic [15:0] oa1;

   int total = 0;
   int bad   = 0;

   booth_mac_unit #(.ACC_W(24), .CNT_W(8)) u_dut24 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .in_a(ia0), .in_b(ib0),
      .in_last(il0), .out_valid(ov0), .out_ready(or0), .out_acc(oa0), .out_count(oc0),
      .out_sat(os0)
   );

   booth_mac_unit #(.ACC_W(16), .CNT_W(8)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .in_a(ia1), .in_b(ib1),
      .in_last(il1), .out_valid(ov1), .out_ready(or1), .out_acc(oa1), .out_count(oc1),
      .out_sat(os1)
   );

   function automatic void model(input int a[$], input int b[$], input int w,
                                 output longint acc, output int cnt, output bit sat);
      longint hi, lo;
      hi  = (longint'(1) <<< (w - 1)) - 1;
      lo  = -hi - 1;
      acc = 0;
      sat = 0;
      foreach (a[i]) begin
         acc += longint'(a[i] * b[i]);
         if (acc > hi) begin acc = hi; sat = 1; end
         else if (acc < lo) begin acc = lo; sat = 1; end
      end
      cnt = (a.size() > 255) ? 255 : a.size();
   endfunction

   task automatic put(input bit sel, input int a, input int b, input bit last);
      int guard = 0;
      while (!(sel ? ir1 : ir0) && guard < 20) begin
         @(posedge clk); #1; guard++;
      end
      total++;
      if (guard >= 20) begin
         bad++;
         $display("FAIL put_ready sel=%0d in_ready stayed 0, required 1", sel);
      end
      if (sel) begin iv1 = 1; ia1 = 8'(a); ib1 = 8'(b); il1 = last; end
      else     begin iv0 = 1; ia0 = 8'(a); ib0 = 8'(b); il0 = last; end
      @(posedge clk); #1;
      iv0 = 0; iv1 = 0; il0 = 0; il1 = 0;
   endtask

   task automatic get(input bit sel, output longint acc, output int cnt, output bit sat);
      int guard = 0;
      while (!(sel ? ov1 : ov0) && guard < 20) begin
         @(posedge clk); #1; guard++;
      end
      total++;
      if (guard >= 20) begin
         bad++;
         $display("FAIL get_valid sel=%0d out_valid stayed 0, required 1", sel);
      end
      acc = sel ? longint'($signed(oa1)) : longint'($signed(oa0));
      cnt = sel ? int'(oc1) : int'(oc0);
      sat = sel ? os1 : os0;
      if (sel) or1 = 1; else or0 = 1;
      @(posedge clk); #1;
      or0 = 0; or1 = 0;
   endtask

   task automatic test_reset();
      rst_n = 0;
      iv0 = 0; ia0 = 0; ib0 = 0; il0 = 0; or0 = 0;
      iv1 = 0; ia1 = 0; ib1 = 0; il1 = 0; or1 = 0;
      #3;
      total++;
      if (ir0 !== 1'b0 || ov0 !== 1'b0 || ir1 !== 1'b0 || ov1 !== 1'b0) begin
         bad++;
         $display("FAIL reset_hs got in_ready=%b/%b out_valid=%b/%b, required 0", ir0, ir1, ov0, ov1);
      end
      total++;
      if (oa0 !== 24'd0 || oc0 !== 8'd0 || os0 !== 1'b0) begin
         bad++;
         $display("FAIL reset_out got acc=%h cnt=%h sat=%b, required 0", oa0, oc0, os0);
      end
      @(negedge clk); rst_n = 1;
      @(posedge clk); #1;
      total++;
      if (ir0 !== 1'b1) begin
         bad++;
         $display("FAIL reset_release got in_ready=%b, required 1", ir0);
      end
   endtask

   task automatic test_single();
      longint acc; int cnt; bit sat;
      put(0, -16, -16, 1);
      total++;
      if (ov0 !== 1'b0) begin
         bad++;
         $display("FAIL single_early got out_valid=%b, required 0", ov0);
      end
      @(posedge clk); #1;
      total++;
      if (ov0 !== 1'b1) begin
         bad++;
         $display("FAIL single_latency got out_valid=%b, required 1", ov0);
      end
      get(0, acc, cnt, sat);
      total++;
      if (acc !== 256 || cnt !== 1 || sat !== 0) begin
         bad++;
         $display("FAIL single got acc=%0d cnt=%0d sat=%0d, required 256 1 0", acc, cnt, sat);
      end
   endtask

   task automatic test_back_to_back();
      longint acc; int cnt; bit sat;
      put(0, 3, 4, 0);
      put(0, -5, 6, 0);
      put(0, 127, -128, 1);
      get(0, acc, cnt, sat);
      total++;
      if (acc !== -16274 || cnt !== 3 || sat !== 0) begin
         bad++;
         $display("FAIL back_to_back got acc=%0d cnt=%0d sat=%0d, required -16274 3 0",
                  acc, cnt, sat);
      end
   endtask

   task automatic test_backpressure();
      logic [23:0] snap_acc;
      logic [7:0]  snap_cnt;
      int guard = 0;
      put(0, 7, -3, 1);
      while (!ov0 && guard < 20) begin @(posedge clk); #1; guard++; end
      snap_acc = oa0;
      snap_cnt = oc0;
      total++;
      if (snap_acc !== 24'hFFFFEB || snap_cnt !== 8'd1) begin
         bad++;
         $display("FAIL bp_value got acc=%h cnt=%0d, required ffffeb 1", snap_acc, snap_cnt);
      end
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         total++;
         if (ir0 !== 1'b0 || ov0 !== 1'b1 || oa0 !== snap_acc || oc0 !== snap_cnt) begin
            bad++;
            $display("FAIL bp_hold cyc=%0d got ir=%b ov=%b acc=%h cnt=%0d, required 0 1 %h %0d",
                     i, ir0, ov0, oa0, oc0, snap_acc, snap_cnt);
         end
      end
      or0 = 1;
      @(posedge clk); #1;
      or0 = 0;
      total++;
      if (ir0 !== 1'b1 || ov0 !== 1'b0) begin
         bad++;
         $display("FAIL bp_release got in_ready=%b out_valid=%b, required 1 0", ir0, ov0);
      end
   endtask

   task automatic test_sat16();
      longint acc; int cnt; bit sat;
      put(1, -128, -128, 0);
      put(1, -128, -128, 0);
      put(1, -128, -128, 1);
      get(1, acc, cnt, sat);
      total++;
      if (acc !== 32767 || cnt !== 3 || sat !== 1) begin
         bad++;
         $display("FAIL sat16 got acc=%0d cnt=%0d sat=%0d, required 32767 3 1", acc, cnt, sat);
      end
      put(1, 2, 3, 1);
      get(1, acc, cnt, sat);
      total++;
      if (acc !== 6 || cnt !== 1 || sat !== 0) begin
         bad++;
         $display("FAIL sat16_next got acc=%0d cnt=%0d sat=%0d, required 6 1 0", acc, cnt, sat);
      end
   endtask

   task automatic test_reset_mid();
      longint acc; int cnt; bit sat;
      put(0, 5, 5, 0);
      put(0, 6, 6, 0);
      #2 rst_n = 0;
      #1;
      total++;
      if (ov0 !== 1'b0 || ir0 !== 1'b0 || oa0 !== 24'd0 || oc0 !== 8'd0 || os0 !== 1'b0) begin
         bad++;
         $display("FAIL reset_mid got ov=%b ir=%b acc=%h cnt=%0d sat=%b, required all 0",
                  ov0, ir0, oa0, oc0, os0);
      end
      @(negedge clk); rst_n = 1;
      @(posedge clk); #1;
      put(0, 1, 1, 1);
      get(0, acc, cnt, sat);
      total++;
      if (acc !== 1 || cnt !== 1 || sat !== 0) begin
         bad++;
         $display("FAIL reset_mid_pkt got acc=%0d cnt=%0d sat=%0d, required 1 1 0", acc, cnt, sat);
      end
   endtask

   task automatic test_bubbles();
      longint acc; int cnt; bit sat;
      put(0, 10, 10, 0);
      repeat (2) begin @(posedge clk); #1; end
      put(0, -1, 5, 1);
      get(0, acc, cnt, sat);
      total++;
      if (acc !== 95 || cnt !== 2 || sat !== 0) begin
         bad++;
         $display("FAIL bubbles got acc=%0d cnt=%0d sat=%0d, required 95 2 0", acc, cnt, sat);
      end
   endtask

   task automatic test_count_sat();
      longint acc; int cnt; bit sat;
      for (int i = 0; i < 300; i++) put(1, 1, 1, i == 299);
      get(1, acc, cnt, sat);
      total++;
      if (acc !== 300 || cnt !== 255 || sat !== 0) begin
         bad++;
         $display("FAIL count_sat got acc=%0d cnt=%0d sat=%0d, required 300 255 0", acc, cnt, sat);
      end
   endtask

   task automatic test_random();
      for (int p = 0; p < 24; p++) begin
         int qa[$], qb[$];
         int len, w;
         bit sel;
         longint acc, eacc; int cnt, ecnt; bit sat, esat;
         sel = 1'($urandom_range(1));
         w   = sel ? 16 : 24;
         len = int'($urandom_range(6, 1));
         for (int t = 0; t < len; t++) begin
            qa.push_back(int'($urandom_range(255)) - 128);
            qb.push_back(int'($urandom_range(255)) - 128);
         end
         for (int t = 0; t < len; t++) begin
            put(sel, qa[t], qb[t], t == len - 1);
            if ($urandom_range(3) == 0) begin @(posedge clk); #1; end
         end
         repeat ($urandom_range(3)) begin @(posedge clk); #1; end
         model(qa, qb, w, eacc, ecnt, esat);
         get(sel, acc, cnt, sat);
         total++;
         if (acc !== eacc || cnt !== ecnt || sat !== esat) begin
            bad++;
            $display("FAIL random pkt=%0d w=%0d got acc=%0d cnt=%0d sat=%0d, required %0d %0d %0d",
                     p, w, acc, cnt, sat, eacc, ecnt, esat);
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation did not finish, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_sat16();
      test_reset_mid();
      test_bubbles();
      test_count_sat();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
